// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of one N-bit adder; each 2N-bit add runs as
// a low half then a high half, with the result held until the consumer takes it.
module adder_arbiter #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [2*N-1:0] req0_a,
  input  logic [2*N-1:0] req0_b,
  input  logic [2*N-1:0] req1_a,
  input  logic [2*N-1:0] req1_b,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [2*N-1:0] resp_sum,
  output logic           resp_cout,
  output logic           resp_id
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t         state, state_nxt;
  logic           ptr;
  logic           id;
  logic [2*N-1:0] op_a, op_b;
  logic [N-1:0]   sum_lo, sum_hi;
  logic           carry;
  logic           cout;

  logic           grant;
  logic           accept;
  logic [N-1:0]   add_a, add_b;
  logic           add_cin;
  logic [N:0]     add_res;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ptr;
  end

  assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  // The single shared adder: operand half and carry-in selected by state.
  always_comb begin
    add_a   = op_a[N-1:0];
    add_b   = op_b[N-1:0];
    add_cin = 1'b0;
    if (state == HIGH) begin
      add_a   = op_a[2*N-1:N];
      add_b   = op_b[2*N-1:N];
      add_cin = carry;
    end
  end

  assign add_res = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = LOW;
      LOW:     state_nxt = HIGH;
      HIGH:    state_nxt = DONE;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      id     <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      sum_lo <= '0;
      sum_hi <= '0;
      carry  <= 1'b0;
      cout   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_a <= grant ? req1_a : req0_a;
            op_b <= grant ? req1_b : req0_b;
            id   <= grant;
            ptr  <= ~grant;
          end
        end
        LOW: begin
          sum_lo <= add_res[N-1:0];
          carry  <= add_res[N];
        end
        HIGH: begin
          sum_hi <= add_res[N-1:0];
          cout   <= add_res[N];
        end
        default: ;
      endcase
    end
  end

  // Result fields read as zero unless a result is actually being presented.
  assign resp_valid = (state == DONE);
  assign resp_sum   = resp_valid ? {sum_hi, sum_lo} : '0;
  assign resp_cout  = resp_valid && cout;
  assign resp_id    = resp_valid && id;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter N, default 16, giving the width of the shared adder datapath; operands and sum are 2N bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports req0_valid and req1_valid  input  1 each  requester i presents an operation.
REQ-005 SHALL have ports req0_ready and req1_ready  output  1 each  requester i's operation is accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  2N each  operands of requester i.
REQ-007 SHALL have port resp_valid  output  1  a result is presented.
REQ-008 SHALL have port resp_ready  input  1  consumer takes the result.
REQ-009 SHALL have port resp_sum  output  2N  result sum, modulo 2^(2N).
REQ-010 SHALL have port resp_cout  output  1  carry out of bit 2N-1.
REQ-011 SHALL have port resp_id  output  1  index of the requester that owns the result.

Function
REQ-012 SHALL contain exactly one N-bit adder with carry-in, time-shared between both requesters and both operand halves.
REQ-013 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-014 IDLE: req_ready SHALL be asserted combinationally to exactly one requester with valid high; with both valid, the one selected by the round-robin pointer wins.
REQ-015 Acceptance (valid & ready on an edge) SHALL latch both 2N-bit operands and the winner id, and move to LOW.
REQ-016 LOW: SHALL add the low N bits with carry-in 0, store the low sum and internal carry, and move to HIGH.
REQ-017 HIGH: SHALL add the high N bits with carry-in equal to the stored carry, store the high sum and resp_cout, and move to DONE.
REQ-018 DONE: resp_valid SHALL be 1; resp_sum, resp_cout and resp_id SHALL be stable until the cycle resp_ready is high, after which the FSM returns to IDLE.
REQ-019 resp_valid SHALL first be high in the third cycle after the acceptance edge, giving a minimum of 4 cycles per operation.
REQ-020 req0_ready and req1_ready SHALL be 0 in LOW, HIGH and DONE; no new request is accepted while a result is pending.
REQ-021 The round-robin pointer SHALL point to the requester not granted, updated on each acceptance; a lone valid requester SHALL be granted regardless of pointer.
REQ-022 Operand inputs SHALL be ignored after acceptance; changing them in LOW/HIGH/DONE SHALL not alter the result.
REQ-023 resp_ready while resp_valid is 0 SHALL have no effect.
REQ-024 resp_sum, resp_cout, resp_id SHALL be 0 whenever resp_valid is 0.

Reset
REQ-025 rst_n low at an edge SHALL force state IDLE, pointer to requester 0, all stored operands, sums and carry to 0, and resp_valid to 0, including mid-operation.
REQ-026 req0_ready and req1_ready SHALL be 0 whenever rst_n is low.
REQ-027 An operation interrupted by reset SHALL be discarded with no response.

Verification
REQ-028 Single op: req0 a=0x0000FFFF, b=0x00000001, resp_ready=1 -> resp_valid at accept+3, resp_sum=0x00010000, cout=0, id=0.
REQ-029 Full carry chain: a=0xFFFFFFFF, b=0x00000001 -> resp_sum=0x00000000, cout=1.
REQ-030 Contention: both valid continuously from reset -> grants alternate 0,1,0,1; resp_id sequence matches.
REQ-031 Backpressure: resp_ready=0 for 5 cycles in DONE -> resp outputs stable, both readys 0; resp_ready=1 -> IDLE next cycle, new grant possible.
REQ-032 Reset in HIGH: rst_n low 1 cycle -> no resp_valid; next request returns correct sum with id from pointer 0.
REQ-033 Operand change after accept: req1 a=0x12345678, b=0x11111111 then inputs changed to 0 -> resp_sum=0x23456789.
